// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing the FIFO write port
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int D_WIDTH   = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                         wr_clk,
    input  logic                         reset,
    input  logic                         f_full,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*D_WIDTH-1:0]   wr_data_in,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         enable_wr,
    output logic [D_WIDTH-1:0]           wr_data,
    output logic                         busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W:0]   NREQ_EXT = (PTR_W + 1)'(NUM_REQ);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [PTR_W-1:0]   owner, owner_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt;
    logic [PTR_W:0]     cand;
    logic [PTR_W-1:0]   sel;
    logic               found;

    always_ff @(posedge wr_clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        owner_nxt     = owner;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        ack           = '0;
        enable_wr     = 1'b0;
        wr_data       = '0;
        busy          = 1'b0;
        cand          = '0;
        sel           = '0;
        found         = 1'b0;

        case (state)
            IDLE: begin
                // First requester at or after rr_ptr, wrapping modulo NUM_REQ
                for (int k = 0; k < NUM_REQ; k++) begin
                    cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
                    if (cand >= NREQ_EXT) begin
                        cand = cand - NREQ_EXT;
                    end
                    sel = cand[PTR_W-1:0];
                    if (!found && req[sel]) begin
                        found     = 1'b1;
                        owner_nxt = sel;
                    end
                end
                if (found) begin
                    state_nxt            = BURST;
                    grant_nxt            = '0;
                    grant_nxt[owner_nxt] = 1'b1;
                    burst_cnt_nxt        = '0;
                end
            end
            BURST: begin
                busy       = 1'b1;
                wr_data    = wr_data_in[owner*D_WIDTH +: D_WIDTH];
                enable_wr  = req[owner] & ~f_full;
                ack[owner] = enable_wr;
                // A stalled last word (f_full high) neither counts nor exits
                if (!req[owner] || (enable_wr && burst_cnt == LAST_CNT)) begin
                    state_nxt  = IDLE;
                    grant_nxt  = '0;
                    rr_ptr_nxt = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                end else if (enable_wr) begin
                    burst_cnt_nxt = burst_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           wr_clk = 1'b0;
    logic           reset;
    logic           f_full;
    logic [N-1:0]   req;
    logic [W-1:0]   pdata [N];
    logic [N*W-1:0] wr_data_in;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic           enable_wr;
    logic [W-1:0]   wr_data;
    logic           busy;

    always #5 wr_clk = ~wr_clk;
    always_comb wr_data_in = {pdata[3], pdata[2], pdata[1], pdata[0]};

    fifo_wr_arbiter #(.NUM_REQ(N), .D_WIDTH(W), .MAX_BURST(MB)) dut (
        .wr_clk     (wr_clk),
        .reset      (reset),
        .f_full     (f_full),
        .req        (req),
        .wr_data_in (wr_data_in),
        .ack        (ack),
        .grant      (grant),
        .enable_wr  (enable_wr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    // Model: owner index (-1 = idle), round-robin start point, words taken in this burst
    int m_owner = -1;
    int m_rr    = 0;
    int m_cnt   = 0;
    bit chk_on  = 1'b0;

    logic [N-1:0] ack_s, grant_s;
    logic         en_s, busy_s;
    logic [W-1:0] data_s;

    logic [9:0]   pat;
    int           nw;
    int           acks [N];
    logic [N-1:0] order [5];
    logic [N-1:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic         m_en;
        logic [N-1:0] m_grant;
        @(negedge wr_clk);
        ack_s   = ack;
        grant_s = grant;
        en_s    = enable_wr;
        busy_s  = busy;
        data_s  = wr_data;
        m_en    = (m_owner >= 0) && req[m_owner] && !f_full;
        m_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        if (chk_on) begin
            chk("grant", grant_s, m_grant);
            chk("ack", ack_s, m_en ? m_grant : '0);
            chk("enable_wr", en_s, m_en);
            chk("busy", busy_s, m_owner >= 0);
            if (m_en) chk("wr_data", data_s, pdata[m_owner]);
            else if (m_owner < 0) chk("wr_data_idle", data_s, 0);
            chk("grant_onehot0", $onehot0(grant_s), 1);
            chk("ack_subset_grant", (ack_s & ~grant_s) == '0, 1);
            chk("en_is_or_ack", en_s == (|ack_s), 1);
            chk("en_not_full", !(en_s && f_full), 1);
        end
        @(posedge wr_clk);
        if (reset) begin
            m_owner = -1;
            m_rr    = 0;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req[(m_rr + k) % N]) begin
                    m_owner = (m_rr + k) % N;
                    m_cnt   = 0;
                end
            end
        end else if (!req[m_owner] || (m_en && m_cnt == MB - 1)) begin
            m_rr    = (m_owner + 1) % N;
            m_owner = -1;
        end else if (m_en) begin
            m_cnt++;
        end
        #1;
        for (int i = 0; i < N; i++) if (ack_s[i]) pdata[i] = pdata[i] + 8'd1;
    endtask

    task automatic idle_out();
        req = '0;
        step();
        step();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        f_full = 1'b0;
        req    = 4'b1111;
        for (int i = 0; i < N; i++) pdata[i] = 8'(i);

        // Reset for two edges with all producers requesting
        step();
        chk_on = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("rst_grant", grant_s, 0);
        chk("rst_ack", ack_s, 0);
        chk("rst_en", en_s, 0);
        chk("rst_busy", busy_s, 0);
        step();
        chk("rst_first_grant", grant_s, 4'b0001);

        // Single producer: two full bursts separated by one bubble
        idle_out();
        pdata[2] = 8'h10;
        req = 4'b0100;
        pat = '0;
        nw  = 0;
        for (int s = 0; s < 10; s++) begin
            step();
            pat = {pat[8:0], en_s};
            if (en_s) begin
                chk("single_data", data_s, 8'h10 + nw);
                nw++;
            end
        end
        chk("single_pattern", pat, 10'b0111101111);
        chk("single_words", nw, 8);

        // Round-robin with everyone requesting
        idle_out();
        pulse_reset();
        req = 4'b1111;
        for (int i = 0; i < N; i++) acks[i] = 0;
        for (int s = 0; s < 22; s++) begin
            step();
            if (s % 5 == 1) order[s / 5] = grant_s;
            if (s < 20) for (int i = 0; i < N; i++) if (ack_s[i]) acks[i]++;
        end
        for (int g = 0; g < 5; g++) chk("rr_order", order[g], exp_order[g]);
        for (int i = 0; i < N; i++) chk("rr_acks", acks[i], MB);

        // Full stall mid-burst on owner 1, other requests ignored until idle
        idle_out();
        pulse_reset();
        pdata[1] = 8'h20;
        req = 4'b0010;
        step();
        step();
        step();
        f_full = 1'b1;
        req = 4'b1010;
        for (int s = 0; s < 6; s++) begin
            step();
            chk("stall_ack", ack_s, 0);
            chk("stall_en", en_s, 0);
            chk("stall_grant", grant_s, 4'b0010);
        end
        f_full = 1'b0;
        step();
        chk("resume_en3", en_s, 1);
        chk("resume_data3", data_s, 8'h22);
        step();
        chk("resume_en4", en_s, 1);
        chk("resume_data4", data_s, 8'h23);
        step();
        chk("rotate_idle", grant_s, 0);
        step();
        chk("rotate_grant", grant_s, 4'b1000);

        // Early release by owner 2; next search starts at 3 and wraps to 0
        idle_out();
        pulse_reset();
        req = 4'b0100;
        step();
        step();
        chk("early_word_en", en_s, 1);
        chk("early_word_grant", grant_s, 4'b0100);
        req = 4'b0000;
        step();
        chk("release_en", en_s, 0);
        chk("release_busy", busy_s, 1);
        req = 4'b0101;
        step();
        chk("release_idle", busy_s, 0);
        step();
        chk("search_wrap", grant_s, 4'b0001);

        // Reset during owner 3's second word, then a full fresh burst
        idle_out();
        pulse_reset();
        req = 4'b1000;
        step();
        step();
        chk("o3_first_en", en_s, 1);
        chk("o3_first_grant", grant_s, 4'b1000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("midrst_grant", grant_s, 0);
        chk("midrst_busy", busy_s, 0);
        chk("midrst_en", en_s, 0);
        for (int s = 0; s < MB; s++) begin
            step();
            chk("restart_en", en_s, 1);
            chk("restart_grant", grant_s, 4'b1000);
        end
        step();
        chk("restart_end", en_s, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single FIFO write port (enable_wr / write data into the write control block) between NUM_REQ independent producers.
- Round-robin arbitration with bounded bursts: a granted producer may write up to MAX_BURST consecutive words before ownership rotates.
- Honours f_full from the flag logic: no word is acknowledged while the FIFO is full.
- Sits in the write clock domain, directly upstream of the write control block.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- D_WIDTH, 8, data word width in bits.
- MAX_BURST, 4, maximum words per grant (1..16).

Ports:
- wr_clk  input  1  write-domain clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- f_full  input  1  FIFO full flag from the flag logic.
- req  input  NUM_REQ  req[i]=1: producer i has a valid word on its data slice.
- wr_data_in  input  NUM_REQ*D_WIDTH  producer data; slice i is bits [i*D_WIDTH +: D_WIDTH].
- ack  output  NUM_REQ  ack[i]=1: producer i's word is written this cycle; the producer advances on the next edge.
- grant  output  NUM_REQ  one-hot current owner, registered; all zero when idle.
- enable_wr  output  1  write enable to the write control block.
- wr_data  output  D_WIDTH  selected producer data to the FIFO memory.
- busy  output  1  high while in state BURST.

Behaviour:
- Reset (reset=1 at an edge):
  - state=IDLE; grant=0; rr_ptr=0; burst_cnt=0.
  - enable_wr=0, ack=0, busy=0 from that edge onward.
  - Reset applied mid-burst aborts the burst immediately; the word in flight that cycle is not acknowledged after the edge.
- State machine, states IDLE and BURST.
- IDLE:
  - If req != 0, pick the first requester with req[i]=1 searching i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register grant = onehot(i); burst_cnt=0; go to BURST.
  - If req == 0, remain in IDLE.
  - No ack or enable_wr is ever issued in IDLE.
- BURST, with owner o = index of grant:
  - Combinational outputs:
    - enable_wr = req[o] & ~f_full.
    - ack[o] = enable_wr; all other ack bits are 0.
    - wr_data = slice o of wr_data_in, driven whenever in BURST; value is don't-care when enable_wr=0; 0 in IDLE.
  - On each cycle with enable_wr=1, burst_cnt increments.
  - Exit to IDLE, with rr_ptr=(o+1) mod NUM_REQ and grant cleared, when either:
    - enable_wr=1 and burst_cnt==MAX_BURST-1 (last word of burst), or
    - req[o]=0 (producer released; no word taken that cycle).
  - f_full=1 with req[o]=1: stall. No ack, burst_cnt holds, grant holds, state holds indefinitely. There is no timeout.
  - f_full deasserting resumes writes on the same cycle it is seen low.
- Latency:
  - req rises in cycle 0 while IDLE -> grant visible from cycle 1 -> first ack/enable_wr in cycle 1 if f_full=0.
  - Each burst is followed by exactly one IDLE cycle (arbitration bubble).
- Fairness:
  - A producer that keeps req high gets at most MAX_BURST words before every other active producer is offered a grant.
  - Worst-case wait is (NUM_REQ-1)*(MAX_BURST+1) cycles plus full-stall time.
- Wrap-around:
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - burst_cnt is clog2(MAX_BURST)+1 bits wide; it never exceeds MAX_BURST-1 and is cleared on entering BURST.
- Simultaneous events:
  - Last-word ack and f_full rising in the same cycle: f_full wins, so no ack and no exit that cycle.
  - req[o] falling and f_full=1 in the same cycle: exit to IDLE.
  - Requests from non-owners are ignored until IDLE.
- Invariants (assert in the bench):
  - grant is one-hot or zero.
  - ack is a subset of grant.
  - enable_wr == |ack.
  - enable_wr implies ~f_full.

Test Plan:
- Reset sequence: reset=1 for 2 cycles with req=4'b1111 -> grant=0, ack=0, enable_wr=0, busy=0 through the cycle after reset falls; grant=4'b0001 one cycle later.
- Single producer: req=4'b0100 held, data 0x10,0x11,... advancing on ack, f_full=0 -> 4 writes 0x10..0x13 in consecutive cycles, one IDLE bubble, then 4 more; enable_wr pattern 1111_0_1111.
- Round-robin: req=4'b1111 held, MAX_BURST=4 -> grant order 0001,0010,0100,1000,0001; exactly 4 acks each; 5-cycle period per owner.
- Full stall: owner 1 mid-burst after 2 words, f_full=1 for 6 cycles -> ack=0, enable_wr=0, grant=4'b0010 held; after f_full=0 exactly 2 more words are written, then ownership rotates.
- Early release: owner 2 drops req after 1 word -> IDLE next cycle, rr_ptr=3; req=4'b0101 then grants owner 0 (search 3,0).
- Mid-burst reset: reset=1 during owner 3's second word -> next cycle grant=0, busy=0, rr_ptr=0; after release with req=4'b1000, owner 3 restarts with burst_cnt=0 and gets a full 4-word burst.
